// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-link program loader. Parses a framed byte stream
//   0xA5 | LEN_HI | LEN_LO | N payload bytes | CSUM (8-bit sum of payload)
// and writes payload byte k to instruction-memory byte address k. The core is
// held in reset until a complete image with a matching checksum is in memory.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   i_in_data/valid   : stream byte and its valid
//   o_in_ready        : byte accepted on a rising edge when valid && ready
//   o_mem_we/addr/wdata : registered byte write port to instruction memory
//   o_core_rst        : core reset, released only after a good load
//   o_done / o_err    : status of the last load
//   o_err_code        : 01 bad length, 10 checksum mismatch, 00 none
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for sync byte 0xA5, other bytes discarded
// LEN_HI   | capture high byte of payload length
// LEN_LO   | capture low byte, validate length
// DATA     | write payload bytes, accumulate sum
// CSUM     | capture checksum byte
// CHECK    | one stall cycle, compare sums
// DONE     | image good, core released, 0xA5 restarts a load
// ERR      | load failed, core held, 0xA5 restarts a load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_core_rst,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0]  SYNC  = 8'hA5;
    // 17 bits so a length equal to the full memory size is representable.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_len_hi, w_len_hi_nxt;
    logic [15:0]       r_len, w_len_nxt;
    logic [15:0]       r_byte_cnt, w_byte_cnt_nxt;
    logic [7:0]        r_sum, w_sum_nxt;
    logic [7:0]        r_csum, w_csum_nxt;
    logic              r_core_rst, w_core_rst_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic [1:0]        r_err_code, w_err_code_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;

    logic              w_accept;
    logic              w_sync;
    logic [15:0]       w_len_in;
    logic [15:0]       w_cnt_inc;

    assign o_in_ready = !rst && (r_state != S_CHECK);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_sync     = w_accept && (i_in_data == SYNC);
    assign w_len_in   = {r_len_hi, i_in_data};
    assign w_cnt_inc  = r_byte_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len_hi    <= '0;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_sum       <= '0;
            r_csum      <= '0;
            r_core_rst  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_len_hi    <= w_len_hi_nxt;
            r_len       <= w_len_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_sum       <= w_sum_nxt;
            r_csum      <= w_csum_nxt;
            r_core_rst  <= w_core_rst_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_err_code  <= w_err_code_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_hi_nxt    = r_len_hi;
        w_len_nxt       = r_len;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_sum_nxt       = r_sum;
        w_csum_nxt      = r_csum;
        w_core_rst_nxt  = r_core_rst;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;
        w_err_code_nxt  = r_err_code;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;

        // A sync byte in IDLE, DONE or ERR starts a fresh load; the core goes
        // back into reset on the same edge and all status is cleared.
        if (w_sync && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR)) begin
            w_state_nxt    = S_LEN_HI;
            w_byte_cnt_nxt = '0;
            w_sum_nxt      = '0;
            w_core_rst_nxt = 1'b1;
            w_done_nxt     = 1'b0;
            w_err_nxt      = 1'b0;
            w_err_code_nxt = 2'b00;
        end

        case (r_state)
            S_LEN_HI: begin
                if (w_accept) begin
                    w_len_hi_nxt = i_in_data;
                    w_state_nxt  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    w_len_nxt = w_len_in;
                    if (({1'b0, w_len_in} > DEPTH) || (w_len_in[1:0] != 2'b00)) begin
                        w_state_nxt    = S_ERR;
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = 2'b01;
                    end else if (w_len_in == 16'd0) begin
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = r_byte_cnt[ADDR_W-1:0];
                    w_mem_wdata_nxt = i_in_data;
                    w_sum_nxt       = r_sum + i_in_data;
                    w_byte_cnt_nxt  = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_csum_nxt  = i_in_data;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_csum == r_sum) begin
                    w_state_nxt    = S_DONE;
                    w_done_nxt     = 1'b1;
                    w_core_rst_nxt = 1'b0;
                end else begin
                    w_state_nxt    = S_ERR;
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = 2'b10;
                end
            end
            S_IDLE, S_DONE, S_ERR: begin
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_core_rst  = r_core_rst;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;

endmodule
